// File: rtl/plugin_dispatcher.sv
// plugin_dispatcher: start/busy/done initiator for a coprocessor plugin; define PLUGIN_DISPATCHER_TIMEOUT_EN to build the watchdog/ABORT path
module plugin_dispatcher #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_rd,
    output logic        hold,
    output logic        plugin_start,
    output logic [31:0] plugin_operand_a,
    output logic [31:0] plugin_operand_b,
    input  logic        plugin_busy,
    input  logic        plugin_done,
    input  logic [31:0] plugin_result,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        error
);
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITEBACK
`ifdef PLUGIN_DISPATCHER_TIMEOUT_EN
        , ABORT
`endif
    } state_t;
    state_t state, state_nx;
    logic timeout;
`ifdef PLUGIN_DISPATCHER_TIMEOUT_EN
    logic [15:0] wd_cnt;
    always_ff @(posedge clk) begin
        if (reset || state == ISSUE)
            wd_cnt <= '0;
        else if (state == WAIT && !plugin_done && wd_cnt != 16'hFFFF)
            wd_cnt <= wd_cnt + 16'd1;
    end
    assign timeout = state == WAIT && wd_cnt == 16'(TIMEOUT_CYCLES - 1);
    assign error = state == ABORT;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = TIMEOUT_CYCLES[0];
    assign timeout = 1'b0;
    assign error = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            plugin_operand_a <= '0;
            plugin_operand_b <= '0;
            wb_rd            <= '0;
            wb_data          <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                plugin_operand_a <= req_rs1;
                plugin_operand_b <= req_rs2;
                wb_rd            <= req_rd;
            end
            if (state == WAIT && plugin_done)
                wb_data <= plugin_result;
        end
    end
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = req_valid ? ISSUE : IDLE;
            ISSUE:   state_nx = plugin_busy ? ISSUE : WAIT;
`ifdef PLUGIN_DISPATCHER_TIMEOUT_EN
            WAIT:    state_nx = plugin_done ? WRITEBACK : timeout ? ABORT : WAIT;
`else
            WAIT:    state_nx = plugin_done ? WRITEBACK : timeout ? IDLE : WAIT;
`endif
            default: state_nx = IDLE;
        endcase
    end
    assign req_ready    = state == IDLE && !reset;
    assign hold         = (state == IDLE && req_valid) || state == ISSUE || state == WAIT;
    assign plugin_start = state == ISSUE && !plugin_busy;
    assign wb_valid     = state == WRITEBACK;
endmodule

// File: tb/tb_plugin_dispatcher.sv
// tb_plugin_dispatcher: randomized self-checking bench; per-operation timing is derived from acceptance, busy length and plugin latency
module tb_plugin_dispatcher;
    localparam int TO = 8;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_rs1 = '0;
    logic [31:0] req_rs2 = '0;
    logic [4:0]  req_rd = '0;
    logic        plugin_busy = 1'b0;
    logic        plugin_done = 1'b0;
    logic [31:0] plugin_result = '0;
    logic        req_ready, hold, plugin_start, wb_valid, error;
    logic [31:0] plugin_operand_a, plugin_operand_b, wb_data;
    logic [4:0]  wb_rd;
    int n_cmp = 0;
    int n_err = 0;

    plugin_dispatcher #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .hold(hold),
        .plugin_start(plugin_start), .plugin_operand_a(plugin_operand_a),
        .plugin_operand_b(plugin_operand_b), .plugin_busy(plugin_busy),
        .plugin_done(plugin_done), .plugin_result(plugin_result),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input bit rdy, input bit hld, input bit st, input bit wb, input bit er);
        check({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
        check({tag, ".hold"}, 32'(hold), 32'(hld));
        check({tag, ".start"}, 32'(plugin_start), 32'(st));
        check({tag, ".wb_valid"}, 32'(wb_valid), 32'(wb));
        check({tag, ".error"}, 32'(error), 32'(er));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation: accept at t=0, busy for bz cycles, start at 1+bz, done lat cycles later, writeback one after done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input int bz, input int lat, input bit nv,
                          input logic [31:0] na, input logic [31:0] nb, input logic [4:0] nrd, input bit spur);
        int sc, dc, wc;
        sc = 1 + bz;
        dc = sc + lat;
        wc = dc + 1;
        for (int t = 0; t <= wc; t++) begin
            req_valid     = (t == 0) || nv;
            req_rs1       = (t == 0) ? a : na;
            req_rs2       = (t == 0) ? b : nb;
            req_rd        = (t == 0) ? rd : nrd;
            plugin_busy   = t >= 1 && t <= bz;
            plugin_done   = t == dc || (spur && t == sc);
            plugin_result = (t == dc) ? a + b + 32'd5 : $urandom;
            @(negedge clk);
            check_ctl("op", t == 0, t < wc, t == sc, t == wc, 1'b0);
            if (t >= 1) begin
                check("op.operand_a", plugin_operand_a, a);
                check("op.operand_b", plugin_operand_b, b);
            end
            if (t == wc) begin
                check("op.wb_rd", 32'(wb_rd), 32'(rd));
                check("op.wb_data", wb_data, a + b + 32'd5);
            end
            step();
        end
        req_valid = 1'b0;
        plugin_busy = 1'b0;
        plugin_done = 1'b0;
    endtask

    task automatic idle(input int n, input bit spur);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'b0;
            plugin_done = spur;
            plugin_result = $urandom;
            @(negedge clk);
            check_ctl("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        plugin_done = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        check("reset.req_ready", 32'(req_ready), 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check_ctl("after_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("after_reset.op_a", plugin_operand_a, 32'd0);
        check("after_reset.op_b", plugin_operand_b, 32'd0);
        check("after_reset.wb_rd", 32'(wb_rd), 32'd0);
        check("after_reset.wb_data", wb_data, 32'd0);
        step();

        run_op(32'd10, 32'd20, 5'd7, 0, 4, 1'b0, '0, '0, '0, 1'b0);
        idle(2, 1'b1);
        run_op(32'hFFFF_FFFF, 32'd1, 5'd3, 0, 3, 1'b1, 32'd2, 32'd2, 5'd4, 1'b0);
        run_op(32'd2, 32'd2, 5'd4, 0, 2, 1'b0, '0, '0, '0, 1'b0);
        idle(1, 1'b0);
        run_op(32'h1234_5678, 32'h0000_1111, 5'd31, 3, 4, 1'b0, '0, '0, '0, 1'b1);
        run_op(32'd100, 32'd1, 5'd1, 0, TO, 1'b0, '0, '0, '0, 1'b0);

        // Reset in WAIT: writeback dropped, registers cleared, late done ignored.
        req_valid = 1'b1; req_rs1 = 32'hDEAD_BEEF; req_rs2 = 32'd7; req_rd = 5'd9;
        step();
        req_valid = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clk);
        check("rst_wait.req_ready", 32'(req_ready), 32'd0);
        check("rst_wait.hold", 32'(hold), 32'd1);
        step();
        reset = 1'b0;
        plugin_done = 1'b1;
        plugin_result = 32'h5555_AAAA;
        @(negedge clk);
        check_ctl("rst_wait.after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_wait.op_a", plugin_operand_a, 32'd0);
        check("rst_wait.op_b", plugin_operand_b, 32'd0);
        check("rst_wait.wb_rd", 32'(wb_rd), 32'd0);
        check("rst_wait.wb_data", wb_data, 32'd0);
        step();
        idle(2, 1'b0);
        run_op(32'd5, 32'd6, 5'd12, 1, 3, 1'b0, '0, '0, '0, 1'b0);

`ifdef PLUGIN_DISPATCHER_TIMEOUT_EN
        // Never-done plugin: start at 1, TO cycles of WAIT, abort at TO+2, late done in IDLE.
        for (int t = 0; t <= TO + 4; t++) begin
            req_valid = t == 0;
            req_rs1 = 32'd1; req_rs2 = 32'd2; req_rd = 5'd6;
            plugin_done = t == TO + 3;
            @(negedge clk);
            check_ctl("wdog", t == 0 || t > TO + 2, t < TO + 2, t == 1, 1'b0, t == TO + 2);
            step();
        end
        plugin_done = 1'b0;
`endif

        for (int i = 0; i < 20; i++) begin
            logic [31:0] a, b;
            logic [4:0] rd;
            a = $urandom; b = $urandom; rd = 5'($urandom);
            run_op(a, b, rd, $urandom_range(0, 3), $urandom_range(1, TO), 1'b0, '0, '0, '0, 1'($urandom));
            idle($urandom_range(0, 2), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_time_limit: run did not finish, got timeout expected completion");
        $fatal(1, "time limit");
    end
endmodule
